// File: rtl/sirv_qspi_flash_seq_pkg.sv
// sirv_qspi_flash_seq_pkg: shared state encoding, protocol codes and shift-count helper
package sirv_qspi_flash_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_WAIT, S_RESP} state_t;
  localparam logic [1:0] PROTO_SINGLE = 2'd0;
  localparam logic [1:0] PROTO_DUAL = 2'd1;
  localparam logic [1:0] PROTO_QUAD = 2'd2;
  function automatic logic [7:0] proto_cnt(input logic [1:0] proto);
    return proto == PROTO_QUAD ? 8'd2 : proto == PROTO_DUAL ? 8'd4 : 8'd8;
  endfunction
endpackage

// File: rtl/sirv_qspi_flash_seq.sv
// sirv_qspi_flash_seq: flash read sequencer issuing cmd/addr/dummy/data byte ops to the QSPI phy
module sirv_qspi_flash_seq
  import sirv_qspi_flash_seq_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DATA_BYTES = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en,
  input  logic [7:0]              cfg_cmd,
  input  logic [1:0]              cfg_cmd_proto,
  input  logic [1:0]              cfg_addr_proto,
  input  logic [1:0]              cfg_data_proto,
  input  logic [4:0]              cfg_dummy,
  input  logic                    cfg_endian,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       req_addr,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [8*DATA_BYTES-1:0] resp_data,
  output logic                    cs_active,
  output logic                    phy_op_valid,
  input  logic                    phy_op_ready,
  output logic                    phy_op_fn,
  output logic                    phy_op_stb,
  output logic [7:0]              phy_op_cnt,
  output logic [7:0]              phy_op_data,
  output logic [1:0]              phy_fmt_proto,
  output logic                    phy_fmt_endian,
  output logic                    phy_fmt_iodir,
  input  logic                    phy_rx_valid,
  input  logic [7:0]              phy_rx_bits
);
  localparam int AB = ADDR_W / 8;
  state_t state, state_n, ret, ret_n;
  logic [2:0] bidx, bidx_n, didx, didx_n;
  logic data_op, data_op_n, cs_n, accept, fire, addr_last;
  logic [7:0] cmd_q;
  logic [1:0] cp_q, ap_q, dp_q;
  logic [4:0] dum_q;
  logic [ADDR_W-1:0] addr_q;
  logic [8*DATA_BYTES-1:0] resp_n;
  assign req_ready = state == S_IDLE && en;
  assign accept = req_valid && req_ready;
  assign phy_op_valid = state inside {S_CMD, S_ADDR, S_DUMMY, S_DATA};
  assign fire = phy_op_valid && phy_op_ready;
  assign resp_valid = state == S_RESP;
  assign addr_last = bidx == 3'(AB - 1);
  assign phy_op_fn = 1'b0;
  assign phy_op_stb = 1'b1;
  // Op payload is a pure function of registered state, so it stays constant while valid waits for ready
  always_comb begin
    phy_op_cnt = '0;
    phy_op_data = '0;
    phy_fmt_proto = '0;
    phy_fmt_iodir = 1'b0;
    case (state)
      S_CMD: begin
        phy_op_cnt = proto_cnt(cp_q);
        phy_op_data = cmd_q;
        phy_fmt_proto = cp_q;
        phy_fmt_iodir = 1'b1;
      end
      S_ADDR: begin
        phy_op_cnt = proto_cnt(ap_q);
        phy_op_data = 8'(addr_q >> (8 * (AB - 1 - int'(bidx))));
        phy_fmt_proto = ap_q;
        phy_fmt_iodir = 1'b1;
      end
      S_DUMMY: begin
        phy_op_cnt = {3'b000, dum_q};
        phy_fmt_proto = ap_q;
      end
      S_DATA: begin
        phy_op_cnt = proto_cnt(dp_q);
        phy_fmt_proto = dp_q;
      end
      default: ;
    endcase
  end
  // Next-state logic: every op fire parks in WAIT, which resumes at the recorded return state
  always_comb begin
    state_n = state;
    ret_n = ret;
    bidx_n = bidx;
    didx_n = didx;
    cs_n = cs_active;
    resp_n = resp_data;
    data_op_n = fire ? state == S_DATA : data_op;
    case (state)
      S_IDLE: if (accept) begin
        state_n = S_CMD;
        bidx_n = '0;
        didx_n = '0;
      end
      S_CMD: if (fire) begin
        state_n = S_WAIT;
        ret_n = S_ADDR;
        cs_n = 1'b1;
      end
      S_ADDR: if (fire) begin
        state_n = S_WAIT;
        bidx_n = addr_last ? 3'd0 : bidx + 3'd1;
        ret_n = !addr_last ? S_ADDR : dum_q != 5'd0 ? S_DUMMY : S_DATA;
      end
      S_DUMMY: if (fire) begin
        state_n = S_WAIT;
        ret_n = S_DATA;
      end
      S_DATA: if (fire) begin
        state_n = S_WAIT;
        ret_n = S_DATA;
      end
      S_WAIT: if (phy_rx_valid) begin
        state_n = ret;
        if (data_op) begin
          resp_n[8*int'(didx) +: 8] = phy_rx_bits;
          didx_n = didx + 3'd1;
          if (didx == 3'(DATA_BYTES - 1)) begin
            state_n = S_RESP;
            cs_n = 1'b0;
          end
        end
      end
      S_RESP: if (resp_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  // State, counters, response word and the config snapshot taken at request accept
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      ret <= S_IDLE;
      bidx <= '0;
      didx <= '0;
      data_op <= 1'b0;
      cs_active <= 1'b0;
      resp_data <= '0;
      cmd_q <= '0;
      cp_q <= '0;
      ap_q <= '0;
      dp_q <= '0;
      dum_q <= '0;
      phy_fmt_endian <= 1'b0;
      addr_q <= '0;
    end else begin
      state <= state_n;
      ret <= ret_n;
      bidx <= bidx_n;
      didx <= didx_n;
      data_op <= data_op_n;
      cs_active <= cs_n;
      resp_data <= resp_n;
      if (accept) begin
        cmd_q <= cfg_cmd;
        cp_q <= cfg_cmd_proto;
        ap_q <= cfg_addr_proto;
        dp_q <= cfg_data_proto;
        dum_q <= cfg_dummy;
        phy_fmt_endian <= cfg_endian;
        addr_q <= req_addr;
      end
    end
  end
endmodule

// File: tb/tb_sirv_qspi_flash_seq.sv
// tb_sirv_qspi_flash_seq: randomized scoreboard bench with a phy/requester model for the read sequencer
module tb_sirv_qspi_flash_seq;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic [7:0] cfg_cmd = '0;
  logic [1:0] cfg_cmd_proto = '0, cfg_addr_proto = '0, cfg_data_proto = '0;
  logic [4:0] cfg_dummy = '0;
  logic cfg_endian = 1'b0;
  logic req_valid = 1'b0;
  logic [23:0] req_addr = '0;
  logic resp_ready = 1'b0;
  logic phy_op_ready = 1'b0;
  logic phy_rx_valid = 1'b0;
  logic [7:0] phy_rx_bits = '0;
  logic req_ready, resp_valid, cs_active, phy_op_valid, phy_op_fn, phy_op_stb;
  logic phy_fmt_endian, phy_fmt_iodir;
  logic [31:0] resp_data;
  logic [7:0] phy_op_cnt, phy_op_data;
  logic [1:0] phy_fmt_proto;

  sirv_qspi_flash_seq #(.ADDR_W(24), .DATA_BYTES(4)) dut (
    .clock(clock), .reset(reset), .en(en),
    .cfg_cmd(cfg_cmd), .cfg_cmd_proto(cfg_cmd_proto), .cfg_addr_proto(cfg_addr_proto),
    .cfg_data_proto(cfg_data_proto), .cfg_dummy(cfg_dummy), .cfg_endian(cfg_endian),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .cs_active(cs_active), .phy_op_valid(phy_op_valid), .phy_op_ready(phy_op_ready),
    .phy_op_fn(phy_op_fn), .phy_op_stb(phy_op_stb), .phy_op_cnt(phy_op_cnt),
    .phy_op_data(phy_op_data), .phy_fmt_proto(phy_fmt_proto), .phy_fmt_endian(phy_fmt_endian),
    .phy_fmt_iodir(phy_fmt_iodir), .phy_rx_valid(phy_rx_valid), .phy_rx_bits(phy_rx_bits)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] cnt;
    logic [7:0] data;
    logic [1:0] proto;
    logic iodir;
    logic endian;
    bit first;
    bit last;
    bit is_data;
    logic [7:0] rxb;
  } op_t;

  op_t exp_ops[$];
  logic [31:0] exp_resp[$];
  int checks = 0, errors = 0, resp_count = 0, data_fires = 0;
  bit stale = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic op_t mk(input logic [7:0] c, input logic [7:0] d, input logic [1:0] p,
                             input logic io, input logic e, input bit f, input bit l,
                             input bit dt, input logic [7:0] rb);
    op_t o;
    o.cnt = c; o.data = d; o.proto = p; o.iodir = io; o.endian = e;
    o.first = f; o.last = l; o.is_data = dt; o.rxb = rb;
    return o;
  endfunction

  // Expected op list built from the transaction description: 8 bits per op, split over 1/2/4 lines
  task automatic do_req(input logic [7:0] cmd, input logic [1:0] cp, input logic [1:0] ap,
                        input logic [1:0] dp, input logic [4:0] dum, input logic endn,
                        input logic [23:0] addr, input logic [31:0] rxw, input bit st, input bit wt);
    bit ok = 0;
    int start;
    exp_ops.push_back(mk(8'(8 >> cp), cmd, cp, 1'b1, endn, 1, 0, 0, 8'h00));
    for (int i = 0; i < 3; i++) exp_ops.push_back(mk(8'(8 >> ap), addr[8*(2-i) +: 8], ap, 1'b1, endn, 0, 0, 0, 8'h00));
    if (dum != 0) exp_ops.push_back(mk({3'b000, dum}, 8'h00, ap, 1'b0, endn, 0, 0, 0, 8'h00));
    for (int i = 0; i < 4; i++) exp_ops.push_back(mk(8'(8 >> dp), 8'h00, dp, 1'b0, endn, 0, i == 3, 1, rxw[8*i +: 8]));
    exp_resp.push_back(rxw);
    data_fires = 0;
    start = resp_count;
    @(posedge clock); #1;
    stale = st; en = 1'b1; req_valid = 1'b1; req_addr = addr;
    cfg_cmd = cmd; cfg_cmd_proto = cp; cfg_addr_proto = ap; cfg_data_proto = dp;
    cfg_dummy = dum; cfg_endian = endn;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (req_ready) begin ok = 1; break; end
    end
    chk("req_accept", 32'(ok), 32'd1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_addr = 24'($urandom); cfg_cmd = 8'($urandom); cfg_cmd_proto = 2'($urandom_range(0, 2));
    cfg_addr_proto = 2'($urandom_range(0, 2)); cfg_data_proto = 2'($urandom_range(0, 2));
    cfg_dummy = 5'($urandom); cfg_endian = 1'($urandom);
    if (wt) begin
      for (int i = 0; i < 3000; i++) begin
        @(posedge clock); #1;
        en = 1'($urandom_range(0, 1));
        if (resp_count != start) break;
      end
      chk("resp_done", 32'(resp_count != start), 32'd1);
      en = 1'b1;
    end
  endtask

  // Phy + requester model and monitor: samples on negedge, drives just after posedge
  initial begin : phy_mon
    op_t e;
    int bp = 0, cd = 0, rw = 0;
    bit snap = 0, rsnap = 0, last_pend = 0, cs_m = 0, fire;
    logic [18:0] s_op;
    logic [31:0] s_resp;
    logic rdy_n = 0, rxv_n = 0, rr_n = 0;
    logic [7:0] rxb_n = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_ops.delete(); exp_resp.delete();
        bp = 0; cd = 0; rw = 0; snap = 0; rsnap = 0; last_pend = 0; cs_m = 0;
        rdy_n = 0; rr_n = 0; rxv_n = stale;
      end else begin
        chk("cs_active", 32'(cs_active), 32'(cs_m));
        if (last_pend && phy_rx_valid) begin last_pend = 0; cs_m = 0; end
        fire = phy_op_valid && phy_op_ready;
        if (phy_op_valid && snap) chk("op_payload_hold", 32'({phy_op_cnt, phy_op_data, phy_fmt_proto, phy_fmt_iodir}), 32'(s_op));
        if (fire) begin
          snap = 0;
          if (exp_ops.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_op: got cnt %h data %h, no op expected", phy_op_cnt, phy_op_data);
            rxb_n = 8'($urandom);
          end else begin
            e = exp_ops.pop_front();
            chk("op_cnt", 32'(phy_op_cnt), 32'(e.cnt));
            chk("op_data", 32'(phy_op_data), 32'(e.data));
            chk("op_proto", 32'(phy_fmt_proto), 32'(e.proto));
            chk("op_iodir", 32'(phy_fmt_iodir), 32'(e.iodir));
            chk("op_endian", 32'(phy_fmt_endian), 32'(e.endian));
            chk("op_fn_stb", 32'({phy_op_fn, phy_op_stb}), 32'd1);
            if (e.first) cs_m = 1;
            if (e.last) last_pend = 1;
            if (e.is_data) data_fires++;
            rxb_n = e.is_data ? e.rxb : 8'($urandom);
          end
          cd = stale ? 0 : $urandom_range(0, 3);
          rxv_n = stale;
          rdy_n = 0;
          bp = ($urandom_range(0, 3) == 0) ? 5 : $urandom_range(0, 1);
        end else begin
          if (cd > 0) cd--; else rxv_n = 1;
          if (phy_op_valid) begin
            snap = 1;
            s_op = {phy_op_cnt, phy_op_data, phy_fmt_proto, phy_fmt_iodir};
            rdy_n = (bp == 0);
            if (bp > 0) bp--;
          end else rdy_n = 0;
        end
        if (resp_valid) begin
          if (resp_ready) begin
            if (exp_resp.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_resp: got %h, no response expected", resp_data);
            end else chk("resp_data", resp_data, exp_resp.pop_front());
            chk("ops_drained", 32'(exp_ops.size()), 32'd0);
            resp_count++;
            rsnap = 0;
            rr_n = 0;
          end else begin
            if (rsnap) chk("resp_hold", resp_data, s_resp); else rw = $urandom_range(0, 3);
            chk("req_ready_in_resp", 32'(req_ready), 32'd0);
            rsnap = 1;
            s_resp = resp_data;
            rr_n = (rw == 0);
            if (rw > 0) rw--;
          end
        end else rr_n = 0;
      end
      @(posedge clock); #1;
      phy_op_ready = rdy_n; phy_rx_valid = rxv_n; phy_rx_bits = rxb_n; resp_ready = rr_n;
    end
  end

  initial begin : stim
    bit ok;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ctrl", 32'({req_ready, resp_valid, cs_active, phy_op_valid, phy_fmt_iodir, phy_fmt_endian, phy_fmt_proto}), 32'd0);
    chk("rst_payload", 32'({phy_op_cnt, phy_op_data}), 32'd0);
    chk("rst_resp", resp_data, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    req_valid = 1'b1; req_addr = 24'($urandom); cfg_cmd = 8'h0B;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("req_ready_en0", 32'(req_ready), 32'd0);
      chk("no_op_en0", 32'(phy_op_valid), 32'd0);
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
    do_req(8'h03, 2'd0, 2'd0, 2'd0, 5'd0, 1'b0, 24'h123456, 32'h44332211, 0, 1);
    do_req(8'h6B, 2'd0, 2'd0, 2'd2, 5'd8, 1'b1, 24'($urandom), $urandom, 0, 1);
    do_req(8'hEB, 2'd0, 2'd2, 2'd2, 5'd6, 1'b0, 24'($urandom), $urandom, 1, 1);
    do_req(8'h3B, 2'd1, 2'd1, 2'd1, 5'd0, 1'b1, 24'($urandom), $urandom, 0, 0);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clock); #1;
      if (data_fires >= 2) begin ok = 1; break; end
    end
    chk("reach_data2", 32'(ok), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_ctrl", 32'({resp_valid, cs_active, phy_op_valid, phy_fmt_iodir, phy_fmt_endian, phy_fmt_proto}), 32'd0);
    chk("midrst_payload", 32'({phy_op_cnt, phy_op_data}), 32'd0);
    chk("midrst_resp", resp_data, 32'd0);
    do_req(8'h03, 2'd0, 2'd0, 2'd0, 5'd0, 1'b0, 24'hABCDEF, 32'hDEADBEEF, 0, 1);
    for (int n = 0; n < 20; n++)
      do_req(8'($urandom), 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
             ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom), 1'($urandom), 24'($urandom), $urandom,
             1'($urandom_range(0, 1)), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sirv_qspi_flash_seq.md
Name: sirv_qspi_flash_seq

Overview:
- Read-transaction sequencer that drives the op/rx interface of the QSPI physical layer to perform memory-mapped flash reads.
- Accepts one word-read request. Issues command, address, dummy and data phases as a series of single-byte physical ops. Assembles the returned bytes into a response word.
- Sits between the flash-XIP bus adapter (requester) and the QSPI physical layer. It is the sole op master of that layer while enabled.

Parameters:
- ADDR_W, 24, flash address width in bits; must be a multiple of 8 (8..32).
- DATA_BYTES, 4, bytes per read response (1..4).

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high reset
- en  in  1  sequencer enable; requests are accepted only when 1
- cfg_cmd  in  8  read command opcode
- cfg_cmd_proto  in  2  protocol for command phase (0 single, 1 dual, 2 quad)
- cfg_addr_proto  in  2  protocol for address and dummy phases
- cfg_data_proto  in  2  protocol for data phase
- cfg_dummy  in  5  dummy sck cycles (0..31)
- cfg_endian  in  1  fmt endian passed to the physical layer
- req_valid  in  1  read request valid
- req_ready  out  1  request accepted this cycle when req_valid & req_ready
- req_addr  in  ADDR_W  byte address
- resp_valid  out  1  response word valid
- resp_ready  in  1  requester accepts response
- resp_data  out  8*DATA_BYTES  read data; byte i is the i-th received byte (little-endian)
- cs_active  out  1  chip-select request to the pad/CS logic; 1 from command issue until last data byte completes
- phy_op_valid  out  1  op valid to the physical layer
- phy_op_ready  in  1  physical layer op ready
- phy_op_fn  out  1  always 0 (transfer)
- phy_op_stb  out  1  always 1 (load fmt with every op)
- phy_op_cnt  out  8  shift count: 8 (single), 4 (dual), 2 (quad); cfg_dummy for the dummy op
- phy_op_data  out  8  transmit byte
- phy_fmt_proto  out  2  protocol for the current op
- phy_fmt_endian  out  1  registered cfg_endian
- phy_fmt_iodir  out  1  1 = transmit; 0 for dummy and data ops
- phy_rx_valid  in  1  physical layer done (level)
- phy_rx_bits  in  8  received byte

Behaviour:
- Reset values: all outputs 0; state IDLE. Configuration and address registers are cleared to 0.
- Config is sampled together with req_addr on request accept and held for the whole transaction. Later cfg changes do not affect a transaction in flight.
- req_ready = (state==IDLE) & en.
- Op handshake: phy_op_valid is held with constant payload until phy_op_valid & phy_op_ready. Payload is registered.
- States:
  - IDLE: on accept, go to CMD.
  - CMD: present cfg_cmd with cfg_cmd_proto and iodir=1. On fire, go to WAIT; next = ADDR.
  - ADDR: present one address byte per op, MSB first (ADDR_W/8 ops), with cfg_addr_proto and iodir=1. A byte counter selects the byte. After the last byte, next = DUMMY if cfg_dummy!=0, else DATA.
  - DUMMY: single op with cnt=cfg_dummy, data=0, iodir=0, proto=cfg_addr_proto.
  - DATA: DATA_BYTES ops with data=0, iodir=0, proto=cfg_data_proto.
  - WAIT: entered the cycle after every fire. Leave when phy_rx_valid=1 to the recorded next state. If the completed op was a DATA op, capture phy_rx_bits into byte slot [data_idx] in that same cycle. After the last data byte, go to RESP.
  - RESP: cs_active=0 and resp_valid=1. Hold resp_data until resp_ready, then go to IDLE.
- WAIT always spends at least 1 cycle, so a stale done level from the previous op is never sampled.
- cs_active: set on the CMD fire cycle; cleared on the cycle WAIT exits after the final data byte.
- en is checked only at request accept; deasserting en mid-transaction does not abort it.
- Synchronous reset in any state: IDLE next cycle, cs_active=0, phy_op_valid=0, any pending resp dropped.
- Widths: byte and data counters are 3 bits wide. phy_op_cnt is zero-extended from 5 bits for the dummy op.

Decomposition:
- Shared package: state encoding (IDLE, CMD, ADDR, DUMMY, DATA, WAIT, RESP), protocol constants (PROTO_SINGLE=0, DUAL=1, QUAD=2) and the proto-to-cnt function.
- No sub-module. The FSM, counters and response register form one module.

Test Plan:
- Single-mode read: cmd=0x03, addr=0x123456, dummy=0, DATA_BYTES=4. Phy model returns 0x11,0x22,0x33,0x44 -> op sequence 03,12,34,56 (cnt=8, iodir=1), then 4 rx ops (iodir=0); resp_data=0x44332211; cs_active high for exactly the op span.
- Quad-output read: cmd=0x6B, cmd_proto=0, addr_proto=0, data_proto=2, dummy=8 -> dummy op cnt=8 and iodir=0; data ops cnt=2 and proto=2.
- Backpressure: phy_op_ready held 0 for 5 cycles on each op -> payload stable throughout, no duplicate ops; resp_ready low for 3 cycles -> resp_data held, req_ready=0.
- Stale done: phy_rx_valid held 1 continuously by the model -> each WAIT lasts exactly 1 cycle and bytes are captured in order; no op is skipped.
- en=0 with req_valid=1 -> req_ready=0 and no ops issued; en toggled low mid-transaction -> transaction completes normally.
- Reset asserted during DATA byte 2 -> next cycle all outputs 0; a new request then completes correctly with fresh data.
